// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared constants and grant encoding for the memory FIFO controller.
package mem_fifo_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_fifo_ctrl_arbiter.sv
// Two-requester alternating-priority arbiter for the single memory port.
// Remembers which side won the last contended cycle and hands the next
// contended cycle to the other side.
module fifo_arbiter
  import mem_fifo_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   rd_req,
  input  logic   wr_req,
  output logic   grant_rd,
  output logic   grant_wr,
  output grant_e last_grant
);

  grant_e last_grant_q;

  // A lone requester always wins; on contention the side that did not win last time goes.
  assign grant_rd   = rd_req & (!wr_req | (last_grant_q == GRANT_WR));
  assign grant_wr   = wr_req & (!rd_req | (last_grant_q == GRANT_RD));
  assign last_grant = last_grant_q;

  // Priority history only moves on contended cycles; flush restores the power-up value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GRANT_WR;
    end else if (flush) begin
      last_grant_q <= GRANT_WR;
    end else if (rd_req && wr_req) begin
      last_grant_q <= (last_grant_q == GRANT_WR) ? GRANT_RD : GRANT_WR;
    end
  end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Circular-buffer FIFO controller in front of a 32x32 register-file memory.
// Holds the pointers, occupancy and one output holding register; the memory
// itself is a separate instance driven through the mem_* pins.
module mem_fifo_ctrl
  import mem_fifo_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_read_e,
  output logic              mem_write_e,
  input  logic [DATA_W-1:0] mem_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              rd_req;
  logic              wr_ok;
  logic              wr_req;
  logic              grant_rd;
  logic              grant_wr;
  grant_e            last_grant;

  assign full      = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty     = (count_q == '0) && !out_valid_q;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Refill the output register whenever it is empty or being popped; flush and reset silence the port.
  assign rd_req = reset & !flush & (count_q != '0) & (!out_valid_q | out_ready);
  assign wr_ok  = !full & !flush;
  assign wr_req = reset & wr_ok & in_valid;

  // A pending read holds off pushes only when the write side won the last contended cycle,
  // so in_valid & in_ready is exactly the arbiter's write grant.
  assign in_ready = reset & wr_ok & !(rd_req & (last_grant == GRANT_WR));

  fifo_arbiter u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .grant_rd   (grant_rd),
    .grant_wr   (grant_wr),
    .last_grant (last_grant)
  );

  // Steer the single memory port: write at wr_ptr, read at rd_ptr, otherwise park on rd_ptr.
  always_comb begin
    mem_address = rd_ptr;
    mem_in      = '0;
    mem_read_e  = 1'b0;
    mem_write_e = 1'b0;
    if (grant_wr) begin
      mem_address = wr_ptr;
      mem_in      = in_data;
      mem_write_e = 1'b1;
    end else if (grant_rd) begin
      mem_read_e = 1'b1;
    end
  end

  // Pointers, occupancy and the output holding register; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (grant_wr) begin
        wr_ptr  <= wr_ptr + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (grant_rd) begin
        rd_ptr      <= rd_ptr + 1'b1;
        count_q     <= count_q - 1'b1;
        out_data_q  <= mem_out;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
